// File: rtl/dmem_access_ctrl.sv
// Load/store access controller between the MEM stage and a word-organised,
// big-endian byte-lane data RAM: alignment check, lane select, load extension, stall.
module dmem_access_ctrl #(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_i,
   input  logic [2:0]        op_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [31:0]       wdata_i,
   input  logic              flush_i,
   output logic              stall_req_o,
   output logic              done_o,
   output logic [31:0]       rdata_o,
   output logic              adel_o,
   output logic              ades_o,
   output logic [ADDR_W-1:0] badaddr_o,
   output logic              mem_ce_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [3:0]        mem_sel_o,
   output logic [31:0]       mem_data_o,
   input  logic [31:0]       mem_data_i
);

   localparam logic [2:0] OP_LB  = 3'b000;
   localparam logic [2:0] OP_LBU = 3'b001;
   localparam logic [2:0] OP_LH  = 3'b010;
   localparam logic [2:0] OP_LHU = 3'b011;
   localparam logic [2:0] OP_LW  = 3'b100;
   localparam logic [2:0] OP_SB  = 3'b101;
   localparam logic [2:0] OP_SH  = 3'b110;
   localparam logic [2:0] OP_SW  = 3'b111;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2,
      EXC    = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [2:0]          op_q, op_d;
   logic [1:0]          boff_q, boff_d;
   logic                exc_st_q, exc_st_d;
   logic                mem_ce_q, mem_ce_d;
   logic                mem_we_q, mem_we_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic [3:0]          mem_sel_q, mem_sel_d;
   logic [31:0]         mem_data_q, mem_data_d;
   logic [31:0]         rdata_q, rdata_d;
   logic [ADDR_W-1:0]   badaddr_q, badaddr_d;

   logic                req_store;
   logic                sz_byte, sz_half, sz_word;
   logic                misaligned;
   logic [3:0]          sel_in;
   logic [31:0]         wdata_rep;
   logic [7:0]          lane_b;
   logic [15:0]         lane_h;
   logic [31:0]         load_ext;

   // Request decode: size class, alignment, big-endian lanes, replicated store data.
   always_comb begin
      req_store = (op_i == OP_SB) || (op_i == OP_SH) || (op_i == OP_SW);
      sz_byte   = (op_i == OP_LB) || (op_i == OP_LBU) || (op_i == OP_SB);
      sz_half   = (op_i == OP_LH) || (op_i == OP_LHU) || (op_i == OP_SH);
      sz_word   = (op_i == OP_LW) || (op_i == OP_SW);
      misaligned = (sz_half && addr_i[0]) || (sz_word && (addr_i[1:0] != 2'b00));
      sel_in    = 4'b1111;
      wdata_rep = wdata_i;
      if (sz_byte) begin
         sel_in    = 4'b1000 >> addr_i[1:0];
         wdata_rep = {4{wdata_i[7:0]}};
      end else if (sz_half) begin
         sel_in    = addr_i[1] ? 4'b0011 : 4'b1100;
         wdata_rep = {2{wdata_i[15:0]}};
      end
   end

   // Load extraction from the lane(s) chosen by the latched address.
   always_comb begin
      lane_b   = mem_data_i[31:24];
      lane_h   = boff_q[1] ? mem_data_i[15:0] : mem_data_i[31:16];
      load_ext = mem_data_i;
      case (boff_q)
         2'b00:   lane_b = mem_data_i[31:24];
         2'b01:   lane_b = mem_data_i[23:16];
         2'b10:   lane_b = mem_data_i[15:8];
         default: lane_b = mem_data_i[7:0];
      endcase
      case (op_q)
         OP_LB:   load_ext = {{24{lane_b[7]}}, lane_b};
         OP_LBU:  load_ext = {24'h000000, lane_b};
         OP_LH:   load_ext = {{16{lane_h[15]}}, lane_h};
         OP_LHU:  load_ext = {16'h0000, lane_h};
         default: load_ext = mem_data_i;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      boff_d     = boff_q;
      exc_st_d   = exc_st_q;
      mem_ce_d   = 1'b0;
      mem_we_d   = 1'b0;
      mem_addr_d = '0;
      mem_sel_d  = 4'b0000;
      mem_data_d = 32'h0;
      rdata_d    = rdata_q;
      badaddr_d  = badaddr_q;
      case (state_q)
         IDLE: begin
            if (req_i) begin
               if (misaligned) begin
                  badaddr_d = addr_i;
                  exc_st_d  = req_store;
                  state_d   = EXC;
               end else begin
                  op_d       = op_i;
                  boff_d     = addr_i[1:0];
                  mem_ce_d   = 1'b1;
                  mem_we_d   = req_store;
                  mem_addr_d = addr_i;
                  mem_sel_d  = sel_in;
                  mem_data_d = wdata_rep;
                  state_d    = ACCESS;
               end
            end
         end
         ACCESS: begin
            if (!mem_we_q) rdata_d = load_ext;
            state_d = RESP;
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      // Flush wins over everything: drop the access and any capture it would make.
      if (flush_i) begin
         state_d    = IDLE;
         mem_ce_d   = 1'b0;
         mem_we_d   = 1'b0;
         mem_addr_d = '0;
         mem_sel_d  = 4'b0000;
         mem_data_d = 32'h0;
         rdata_d    = rdata_q;
         badaddr_d  = badaddr_q;
         exc_st_d   = exc_st_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         op_q       <= 3'b000;
         boff_q     <= 2'b00;
         exc_st_q   <= 1'b0;
         mem_ce_q   <= 1'b0;
         mem_we_q   <= 1'b0;
         mem_addr_q <= '0;
         mem_sel_q  <= 4'b0000;
         mem_data_q <= 32'h0;
         rdata_q    <= 32'h0;
         badaddr_q  <= '0;
      end else begin
         state_q    <= state_d;
         op_q       <= op_d;
         boff_q     <= boff_d;
         exc_st_q   <= exc_st_d;
         mem_ce_q   <= mem_ce_d;
         mem_we_q   <= mem_we_d;
         mem_addr_q <= mem_addr_d;
         mem_sel_q  <= mem_sel_d;
         mem_data_q <= mem_data_d;
         rdata_q    <= rdata_d;
         badaddr_q  <= badaddr_d;
      end
   end

   // Flush gates the RAM strobes combinationally so a flushed store never commits.
   assign mem_ce_o    = mem_ce_q & ~flush_i;
   assign mem_we_o    = mem_we_q & ~flush_i;
   assign mem_addr_o  = mem_addr_q;
   assign mem_sel_o   = mem_sel_q;
   assign mem_data_o  = mem_data_q;
   assign rdata_o     = rdata_q;
   assign badaddr_o   = badaddr_q;
   assign done_o      = (state_q == RESP) & ~flush_i;
   assign adel_o      = (state_q == EXC) & ~exc_st_q & ~flush_i;
   assign ades_o      = (state_q == EXC) & exc_st_q & ~flush_i;
   assign stall_req_o = req_i & ~rst & ((state_q == IDLE) | (state_q == ACCESS));

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Bench for dmem_access_ctrl: behavioural byte-lane RAM, byte-addressed reference
// memory for expected load data, scoreboard queue of expected load results.
module tb_dmem_access_ctrl;

   localparam logic [2:0] LB = 3'd0, LBU = 3'd1, LH = 3'd2, LHU = 3'd3,
                          LW = 3'd4, SB = 3'd5, SH = 3'd6, SW = 3'd7;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_i, flush_i;
   logic [2:0]  op_i;
   logic [31:0] addr_i, wdata_i;
   logic        stall_req_o, done_o, adel_o, ades_o;
   logic [31:0] rdata_o, badaddr_o;
   logic        mem_ce_o, mem_we_o;
   logic [31:0] mem_addr_o, mem_data_o, mem_data_i;
   logic [3:0]  mem_sel_o;

   int n_chk = 0;
   int n_err = 0;
   logic [31:0] exp_q[$];

   logic [31:0] ram   [0:255];
   logic [7:0]  ref_b [0:1023];

   always #5 clk = ~clk;

   dmem_access_ctrl #(.ADDR_W(32)) dut (
      .clk(clk), .rst(rst), .req_i(req_i), .op_i(op_i), .addr_i(addr_i),
      .wdata_i(wdata_i), .flush_i(flush_i), .stall_req_o(stall_req_o),
      .done_o(done_o), .rdata_o(rdata_o), .adel_o(adel_o), .ades_o(ades_o),
      .badaddr_o(badaddr_o), .mem_ce_o(mem_ce_o), .mem_we_o(mem_we_o),
      .mem_addr_o(mem_addr_o), .mem_sel_o(mem_sel_o), .mem_data_o(mem_data_o),
      .mem_data_i(mem_data_i)
   );

   assign mem_data_i = ram[mem_addr_o[9:2]];

   always @(posedge clk) begin
      if (mem_ce_o && mem_we_o) begin
         for (int k = 0; k < 4; k++)
            if (mem_sel_o[k]) ram[mem_addr_o[9:2]][8*k +: 8] <= mem_data_o[8*k +: 8];
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got=0x%08h expected=0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] ref_load(input logic [2:0] op, input logic [31:0] a);
      logic [9:0]  i;
      logic [15:0] h;
      i = a[9:0];
      h = {ref_b[i], ref_b[i + 10'd1]};
      case (op)
         LB:      return {{24{ref_b[i][7]}}, ref_b[i]};
         LBU:     return {24'h0, ref_b[i]};
         LH:      return {{16{h[15]}}, h};
         LHU:     return {16'h0, h};
         default: return {ref_b[i], ref_b[i + 10'd1], ref_b[i + 10'd2], ref_b[i + 10'd3]};
      endcase
   endfunction

   task automatic ref_store(input logic [2:0] op, input logic [31:0] a, input logic [31:0] wd);
      logic [9:0] i;
      i = a[9:0];
      if (op == SB) ref_b[i] = wd[7:0];
      else if (op == SH) begin
         ref_b[i] = wd[15:8]; ref_b[i + 10'd1] = wd[7:0];
      end else begin
         ref_b[i] = wd[31:24]; ref_b[i + 10'd1] = wd[23:16];
         ref_b[i + 10'd2] = wd[15:8]; ref_b[i + 10'd3] = wd[7:0];
      end
   endtask

   // Drive one request (called #1 after a rising edge) and follow it to completion.
   task automatic run_req(input logic [2:0] op, input logic [31:0] a, input logic [31:0] wd,
                          input bit flush_acc);
      bit          ld, mis, fin, bsz, hsz;
      logic [3:0]  esel;
      logic [31:0] edata, e;
      int          stalls, ce_cnt;
      ld  = (op <= LW);
      bsz = (op == LB) || (op == LBU) || (op == SB);
      hsz = (op == LH) || (op == LHU) || (op == SH);
      mis = (hsz && a[0]) || (!bsz && !hsz && (a[1:0] != 2'b00));
      if (bsz) begin
         esel = 4'b1000 >> a[1:0]; edata = {4{wd[7:0]}};
      end else if (hsz) begin
         esel = a[1] ? 4'b0011 : 4'b1100; edata = {2{wd[15:0]}};
      end else begin
         esel = 4'b1111; edata = wd;
      end
      if (!mis && !flush_acc) begin
         if (ld) exp_q.push_back(ref_load(op, a));
         else ref_store(op, a, wd);
      end
      req_i = 1'b1; op_i = op; addr_i = a; wdata_i = wd;
      stalls = 0; ce_cnt = 0; fin = 1'b0;
      for (int c = 0; c < 8 && !fin; c++) begin
         @(negedge clk);
         if (flush_acc && c == 1) begin
            check_eq("fl_ce_pre", 32'(mem_ce_o), 32'd1);
            check_eq("fl_stall", 32'(stalls), 32'd1);
            flush_i = 1'b1;
            #1;
            check_eq("fl_ce", 32'(mem_ce_o), 32'd0);
            check_eq("fl_we", 32'(mem_we_o), 32'd0);
            check_eq("fl_done", 32'(done_o), 32'd0);
            @(posedge clk);
            #1;
            flush_i = 1'b0; req_i = 1'b0;
            @(negedge clk);
            check_eq("fl_after_done", 32'(done_o), 32'd0);
            check_eq("fl_after_ce", 32'(mem_ce_o), 32'd0);
            @(posedge clk);
            #1;
            return;
         end
         if (stall_req_o) stalls++;
         if (mem_ce_o) begin
            ce_cnt++;
            check_eq("acc_cycle", 32'(c), 32'd1);
            check_eq("mem_we", 32'(mem_we_o), 32'(!ld));
            check_eq("mem_sel", 32'(mem_sel_o), 32'(esel));
            check_eq("mem_addr", mem_addr_o, a);
            if (!ld) check_eq("mem_data", mem_data_o, edata);
         end
         if (done_o) begin
            fin = 1'b1;
            check_eq("kind_done", 32'(mis), 32'd0);
            check_eq("done_lat", 32'(c), 32'd2);
            if (ld) begin
               if (exp_q.size() == 0) check_eq("sb_empty", 32'd1, 32'd0);
               else begin
                  e = exp_q.pop_front();
                  check_eq("rdata", rdata_o, e);
               end
            end
         end
         if (adel_o || ades_o) begin
            fin = 1'b1;
            check_eq("kind_exc", 32'(mis), 32'd1);
            check_eq("exc_lat", 32'(c), 32'd1);
            check_eq("adel", 32'(adel_o), 32'(ld));
            check_eq("ades", 32'(ades_o), 32'(!ld));
            check_eq("badaddr", badaddr_o, a);
         end
      end
      if (!fin) check_eq("timeout", 32'd0, 32'd1);
      check_eq("stalls", 32'(stalls), mis ? 32'd1 : 32'd2);
      check_eq("ce_cycles", 32'(ce_cnt), mis ? 32'd0 : 32'd1);
      @(posedge clk);
      #1;
      req_i = 1'b0;
   endtask

   // Load request aborted by an asynchronous reset in its ACCESS cycle.
   task automatic run_reset_abort(input logic [31:0] a);
      req_i = 1'b1; op_i = LW; addr_i = a; wdata_i = 32'h0;
      @(negedge clk);
      @(negedge clk);
      check_eq("rst_pre_ce", 32'(mem_ce_o), 32'd1);
      rst = 1'b1;
      #1;
      check_eq("rst_ce", 32'(mem_ce_o), 32'd0);
      check_eq("rst_we", 32'(mem_we_o), 32'd0);
      check_eq("rst_sel", 32'(mem_sel_o), 32'd0);
      check_eq("rst_addr", mem_addr_o, 32'd0);
      check_eq("rst_data", mem_data_o, 32'd0);
      check_eq("rst_rdata", rdata_o, 32'd0);
      check_eq("rst_badaddr", badaddr_o, 32'd0);
      check_eq("rst_done", 32'(done_o), 32'd0);
      check_eq("rst_stall", 32'(stall_req_o), 32'd0);
      @(negedge clk);
      req_i = 1'b0;
      rst = 1'b0;
      @(posedge clk);
      #1;
      check_eq("rst_after_done", 32'(done_o), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [2:0]  rop;
      logic [31:0] ra, rd;
      for (int i = 0; i < 256; i++) ram[i] = 32'h0;
      for (int i = 0; i < 1024; i++) ref_b[i] = 8'h0;
      rst = 1'b1; req_i = 1'b0; flush_i = 1'b0; op_i = 3'd0; addr_i = 32'h0; wdata_i = 32'h0;
      repeat (2) @(posedge clk);
      #1;
      check_eq("reset_ce", 32'(mem_ce_o), 32'd0);
      check_eq("reset_done", 32'(done_o), 32'd0);
      check_eq("reset_rdata", rdata_o, 32'd0);
      check_eq("reset_exc", 32'({adel_o, ades_o}), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;

      run_req(SW, 32'h100, 32'hDEADBEEF, 1'b0);
      run_req(LW, 32'h100, 32'h0, 1'b0);
      run_req(SW, 32'h100, 32'h0, 1'b0);
      run_req(SB, 32'h103, 32'h80, 1'b0);
      run_req(LB, 32'h103, 32'h0, 1'b0);
      run_req(LBU, 32'h103, 32'h0, 1'b0);
      run_req(SH, 32'h102, 32'h8001, 1'b0);
      run_req(LH, 32'h102, 32'h0, 1'b0);
      run_req(LHU, 32'h100, 32'h0, 1'b0);
      run_req(LW, 32'h100, 32'h0, 1'b0);
      run_req(LW, 32'h102, 32'h0, 1'b0);
      run_req(SH, 32'h101, 32'h1234, 1'b0);
      run_req(LH, 32'h103, 32'h0, 1'b0);
      run_req(SW, 32'h201, 32'h55, 1'b0);
      run_req(SW, 32'h200, 32'h12345678, 1'b0);
      run_req(SW, 32'h200, 32'hCAFEF00D, 1'b1);
      run_req(LW, 32'h200, 32'h0, 1'b0);
      run_req(SB, 32'h201, 32'hA5, 1'b0);
      run_req(LBU, 32'h201, 32'h0, 1'b0);
      run_reset_abort(32'h200);
      run_req(LW, 32'h200, 32'h0, 1'b0);

      for (int n = 0; n < 40; n++) begin
         rop = 3'($urandom_range(0, 7));
         ra  = 32'($urandom_range(0, 1020));
         rd  = $urandom;
         run_req(rop, ra, rd, 1'b0);
      end

      check_eq("sb_drained", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
